// File: rtl/pulse_interval_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pulse_interval_monitor
// Purpose  : Synchronizes a pulse train, detects rising edges and measures
//            the clock-cycle distance between consecutive edges. Each
//            interval is classified against a min/max window (latched at the
//            interval's opening edge) and returned through a single-entry
//            valid/ready output register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous active-high reset
//   pulse_in     in   1      pulse train, may be asynchronous to clk
//   enable       in   1      1 = monitoring active, 0 = forces IDLE
//   min_gap      in   CNT_W  minimum legal edge-to-edge distance
//   max_gap      in   CNT_W  maximum legal distance, 0 = no upper limit
//   meas_valid   out  1      result held on meas_gap/meas_err
//   meas_ready   in   1      consumer accepts the result
//   meas_gap     out  CNT_W  measured distance in cycles (saturated)
//   meas_err     out  2      00 OK, 01 SHORT, 10 LONG
//   pulse_count  out  16     saturating count of edges seen while active
//   overflow     out  1      sticky: a result was dropped
// ============================================================================
module pulse_interval_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] min_gap,
  input  logic [CNT_W-1:0] max_gap,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_gap,
  output logic [1:0]       meas_err,
  output logic [15:0]      pulse_count,
  output logic             overflow
);

  localparam logic [1:0]       c_ERR_OK    = 2'b00;
  localparam logic [1:0]       c_ERR_SHORT = 2'b01;
  localparam logic [1:0]       c_ERR_LONG  = 2'b10;
  localparam logic [CNT_W-1:0] c_GC_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   c_DIST_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [15:0]      c_CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_MEASURE    = 2'd2
  } state_t;

  // Registered state
  logic [SYNC_STAGES-1:0] sync_q,       sync_d;
  logic                   s_d_q,        s_d_d;
  state_t                 state_q,      state_d;
  logic [CNT_W-1:0]       gc_q,         gc_d;
  logic [CNT_W-1:0]       min_sh_q,     min_sh_d;
  logic [CNT_W-1:0]       max_sh_q,     max_sh_d;
  logic [15:0]            pulse_cnt_q,  pulse_cnt_d;
  logic                   overflow_q,   overflow_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]       meas_gap_q,   meas_gap_d;
  logic [1:0]             meas_err_q,   meas_err_d;

  // Combinational helpers
  logic                   w_rise;
  logic [CNT_W:0]         w_dist;
  logic [CNT_W-1:0]       w_dist_sat;
  logic                   w_max_on;
  logic                   w_timeout;
  logic                   w_short;
  logic                   w_long;
  logic                   w_can_load;
  logic                   w_res_fire;
  logic [1:0]             w_res_err;

  assign w_rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

  // Distance is one more than the counter because the counter is zeroed
  // in the opening edge cycle itself; carried at CNT_W+1 bits so the
  // saturated counter still compares correctly against max_sh + 1.
  assign w_dist     = {1'b0, gc_q} + c_DIST_ONE;
  assign w_dist_sat = w_dist[CNT_W] ? {CNT_W{1'b1}} : w_dist[CNT_W-1:0];
  assign w_max_on   = (max_sh_q != '0);
  assign w_timeout  = w_max_on && (w_dist == ({1'b0, max_sh_q} + c_DIST_ONE));
  assign w_short    = (w_dist < {1'b0, min_sh_q});
  assign w_long     = w_max_on && (w_dist > {1'b0, max_sh_q});

  // Full throughput: a result may load in the same cycle the held one leaves.
  assign w_can_load = ~meas_valid_q | meas_ready;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], pulse_in};
    s_d_d        = sync_q[SYNC_STAGES-1];
    state_d      = state_q;
    gc_d         = gc_q;
    min_sh_d     = min_sh_q;
    max_sh_d     = max_sh_q;
    pulse_cnt_d  = pulse_cnt_q;
    overflow_d   = overflow_q;
    meas_valid_d = meas_valid_q;
    meas_gap_d   = meas_gap_q;
    meas_err_d   = meas_err_q;
    w_res_fire   = 1'b0;
    w_res_err    = c_ERR_OK;

    // Each interval is judged with the window present at its opening edge.
    if (w_rise) begin
      min_sh_d = min_gap;
      max_sh_d = max_gap;
    end

    // An edge coinciding with enable falling is still counted, since the
    // FSM is not yet in IDLE during that cycle.
    if (w_rise && (state_q != ST_IDLE) && (pulse_cnt_q != c_CNT_MAX)) begin
      pulse_cnt_d = pulse_cnt_q + 16'd1;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      gc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_FIRST;
          gc_d    = '0;
        end
        ST_WAIT_FIRST: begin
          gc_d = '0;
          if (w_rise) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            // An edge on the timeout cycle wins and classifies as LONG.
            gc_d       = '0;
            w_res_fire = 1'b1;
            if (w_short) begin
              w_res_err = c_ERR_SHORT;
            end else if (w_long) begin
              w_res_err = c_ERR_LONG;
            end else begin
              w_res_err = c_ERR_OK;
            end
          end else begin
            gc_d = (&gc_q) ? gc_q : (gc_q + c_GC_ONE);
            if (w_timeout) begin
              w_res_fire = 1'b1;
              w_res_err  = c_ERR_LONG;
              state_d    = ST_WAIT_FIRST;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          gc_d    = '0;
        end
      endcase
    end

    // Single-entry output register; an occupied, stalled entry drops the
    // new result and flags it.
    if (w_res_fire) begin
      if (w_can_load) begin
        meas_valid_d = 1'b1;
        meas_gap_d   = w_dist_sat;
        meas_err_d   = w_res_err;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (meas_valid_q && meas_ready) begin
      meas_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      state_q      <= ST_IDLE;
      gc_q         <= '0;
      min_sh_q     <= '0;
      max_sh_q     <= '0;
      pulse_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      meas_valid_q <= 1'b0;
      meas_gap_q   <= '0;
      meas_err_q   <= c_ERR_OK;
    end else begin
      sync_q       <= sync_d;
      s_d_q        <= s_d_d;
      state_q      <= state_d;
      gc_q         <= gc_d;
      min_sh_q     <= min_sh_d;
      max_sh_q     <= max_sh_d;
      pulse_cnt_q  <= pulse_cnt_d;
      overflow_q   <= overflow_d;
      meas_valid_q <= meas_valid_d;
      meas_gap_q   <= meas_gap_d;
      meas_err_q   <= meas_err_d;
    end
  end

  assign meas_valid  = meas_valid_q;
  assign meas_gap    = meas_gap_q;
  assign meas_err    = meas_err_q;
  assign pulse_count = pulse_cnt_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_interval_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_interval_monitor
// Purpose  : Self-checking bench for pulse_interval_monitor. A timestamp
//            based reference model predicts results into a queue; a monitor
//            pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_interval_monitor;

  localparam int CNT_W = 16;
  localparam int S     = 2;

  typedef struct packed {
    logic [15:0] gap;
    logic [1:0]  err;
  } res_t;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        pulse_in   = 1'b0;
  logic        enable     = 1'b0;
  logic        meas_ready = 1'b0;
  logic [15:0] min_gap    = '0;
  logic [15:0] max_gap    = '0;
  logic        meas_valid;
  logic [15:0] meas_gap;
  logic [1:0]  meas_err;
  logic [15:0] pulse_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  pulse_interval_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .enable      (enable),
    .min_gap     (min_gap),
    .max_gap     (max_gap),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_gap    (meas_gap),
    .meas_err    (meas_err),
    .pulse_count (pulse_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Edges are timestamps; a result is the difference between timestamps.
  int          cyc = 0;
  bit          hist [0:S];
  int          m_mode = 0;       // 0 idle, 1 waiting for first edge, 2 measuring
  int          m_open = 0;
  int          m_mn = 0;
  int          m_mx = 0;
  int          m_gap;
  bit          m_rise;
  bit          m_emit;
  res_t        m_res;
  bit          m_occ = 1'b0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_count = '0;
  res_t        exp_q [$];
  res_t        got_q [$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int k = 0; k <= S; k++) hist[k] = 1'b0;
      m_mode  = 0;
      m_occ   = 1'b0;
      m_ovf   = 1'b0;
      m_count = '0;
      exp_q.delete();
    end else begin
      // Edge is visible S cycles after the pin is first sampled high.
      m_rise = hist[S-1] && !hist[S];
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pulse_in;
      m_emit  = 1'b0;
      if (m_rise && m_mode != 0 && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (!enable) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_rise) begin
          m_mode = 2; m_open = cyc; m_mn = int'(min_gap); m_mx = int'(max_gap);
        end
      end else begin
        m_gap = cyc - m_open;
        if (m_rise) begin
          m_emit = 1'b1;
          m_res.gap = (m_gap > 65535) ? 16'hFFFF : m_gap[15:0];
          if (m_gap < m_mn) m_res.err = 2'b01;
          else if (m_mx != 0 && m_gap > m_mx) m_res.err = 2'b10;
          else m_res.err = 2'b00;
          m_open = cyc; m_mn = int'(min_gap); m_mx = int'(max_gap);
        end else if (m_mx != 0 && m_gap == m_mx + 1) begin
          m_emit = 1'b1;
          m_res.gap = (m_gap > 65535) ? 16'hFFFF : m_gap[15:0];
          m_res.err = 2'b10;
          m_mode = 1;
        end
      end
      if (m_emit) begin
        if (m_occ && !meas_ready) m_ovf = 1'b1;
        else begin exp_q.push_back(m_res); m_occ = 1'b1; end
      end else if (m_occ && meas_ready) begin
        m_occ = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------- monitor
  res_t mon_e;
  always @(negedge clk) begin
    check("meas_valid", int'(meas_valid), int'(m_occ));
    check("pulse_count", int'(pulse_count), int'(m_count));
    check("overflow", int'(overflow), int'(m_ovf));
    if (meas_valid && meas_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("meas_gap", int'(meas_gap), int'(mon_e.gap));
        check("meas_err", int'(meas_err), int'(mon_e.err));
      end
      got_q.push_back({meas_gap, meas_err});
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) meas_ready = 1'($urandom_range(0, 1));
  endtask

  // One-cycle high pulse followed by gap-1 low cycles: edges spaced by gap.
  task automatic pulse(input int gap);
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    for (int k = 1; k < gap; k++) step();
  endtask

  initial begin
    enable = 1'b1; meas_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_in = ~pulse_in;
      step();
    end
    check("reset_count", int'(pulse_count), 0);
    check("reset_valid", int'(meas_valid), 0);
    check("reset_ovf", int'(overflow), 0);
    reset = 1'b0; pulse_in = 1'b0; min_gap = 16'd4; max_gap = 16'd20;
    repeat (5) step();

    // Basic window: 5 OK, 2 SHORT, timeout 21 LONG, restart edge.
    got_q.delete();
    pulse(5); pulse(2); pulse(23); pulse(10);
    check("basic_n", got_q.size(), 3);
    check("basic_gap0", int'(got_q[0].gap), 5);
    check("basic_err0", int'(got_q[0].err), 0);
    check("basic_gap1", int'(got_q[1].gap), 2);
    check("basic_err1", int'(got_q[1].err), 1);
    check("basic_gap2", int'(got_q[2].gap), 21);
    check("basic_err2", int'(got_q[2].err), 2);
    check("basic_count", int'(pulse_count), 4);

    // Enable dropped mid-interval.
    enable = 1'b0; repeat (3) step();
    enable = 1'b1; repeat (2) step();
    check("dis_n", got_q.size(), 3);
    check("dis_count", int'(pulse_count), 4);

    // Window change while an interval is open.
    got_q.delete();
    pulse(6); pulse(5);
    min_gap = 16'd10;
    pulse(7); pulse(7);
    repeat (25) step();
    check("win_n", got_q.size(), 4);
    check("win_gap0", int'(got_q[0].gap), 6);
    check("win_err0", int'(got_q[0].err), 0);
    check("win_gap1", int'(got_q[1].gap), 5);
    check("win_err1", int'(got_q[1].err), 0);
    check("win_gap2", int'(got_q[2].gap), 7);
    check("win_err2", int'(got_q[2].err), 1);
    check("win_gap3", int'(got_q[3].gap), 21);
    check("win_err3", int'(got_q[3].err), 2);

    // Back-pressure: first result held, later ones dropped.
    min_gap = 16'd4; meas_ready = 1'b0;
    got_q.delete();
    pulse(5); pulse(5); pulse(5); pulse(5);
    repeat (3) step();
    check("bp_ovf", int'(overflow), 1);
    check("bp_valid", int'(meas_valid), 1);
    check("bp_held", int'(meas_gap), 5);
    meas_ready = 1'b1;
    repeat (3) step();
    check("bp_n", got_q.size(), 1);
    check("bp_gap", int'(got_q[0].gap), 5);
    check("bp_err", int'(got_q[0].err), 0);
    enable = 1'b0; repeat (3) step();
    check("ovf_retained", int'(overflow), 1);

    // No upper limit, interval longer than the counter range.
    min_gap = 16'd0; max_gap = 16'd0; enable = 1'b1;
    repeat (2) step();
    got_q.delete();
    pulse(70000); pulse(10);
    check("sat_n", got_q.size(), 1);
    check("sat_gap", int'(got_q[0].gap), 65535);
    check("sat_err", int'(got_q[0].err), 0);

    // Random intervals, windows, back-pressure and a mid-run reset.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      min_gap = 16'($urandom_range(0, 12));
      max_gap = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(4, 30));
      if (i == 20) begin
        reset = 1'b1; step(); step(); reset = 1'b0;
        check("midreset_ovf", int'(overflow), 0);
        check("midreset_valid", int'(meas_valid), 0);
      end
      if (i % 13 == 7) begin
        enable = 1'b0; step(); step(); enable = 1'b1;
      end
      pulse($urandom_range(2, 35));
    end
    rand_ready = 1'b0; meas_ready = 1'b1;
    repeat (40) step();
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
